// File: rtl/motor_drive_ctrl.sv
// Two-wheel H-bridge drive: turns direction-FSM codes into ramped, dead-timed
// PWM and direction pins for the left and right motors.

module motor_drive_wheel #(
    parameter int unsigned RAMP_STEP = 4,
    parameter int unsigned DEADTIME  = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       estop,
    input  logic       ramp_tick,
    input  logic [7:0] pwm_cnt,
    input  logic [7:0] tgt_mag,
    input  logic       tgt_fwd,
    output logic       pwm,
    output logic       fwd,
    output logic       on_target
);
    localparam int unsigned DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME - 1);
    localparam logic [7:0] STEP = 8'(RAMP_STEP);

    typedef enum logic {W_RUN, W_DEAD} wheel_state_t;

    wheel_state_t      state, state_n;
    logic [7:0]        mag, mag_n;
    logic              fwd_n;
    logic [DEAD_W-1:0] dead_cnt, dead_n;
    logic              agrees;

    // A zero target never asks for a reversal, so the current dir is kept.
    assign agrees    = (tgt_mag == 8'd0) || (tgt_fwd == fwd);
    assign on_target = (state == W_RUN) && (mag == tgt_mag) && agrees;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        mag_n   = mag;
        fwd_n   = fwd;
        dead_n  = dead_cnt;
        if (estop) begin
            state_n = W_RUN;
            mag_n   = 8'd0;
            dead_n  = '0;
        end else begin
            case (state)
                W_RUN: begin
                    if (ramp_tick) begin
                        if (agrees) begin
                            if (mag < tgt_mag)
                                mag_n = ((tgt_mag - mag) > STEP) ? mag + STEP : tgt_mag;
                            else if (mag > tgt_mag)
                                mag_n = ((mag - tgt_mag) > STEP) ? mag - STEP : tgt_mag;
                        end else if (mag != 8'd0) begin
                            mag_n = (mag > STEP) ? mag - STEP : 8'd0;
                        end else begin
                            state_n = W_DEAD;
                            dead_n  = '0;
                        end
                    end
                end
                W_DEAD: begin
                    if (agrees) begin
                        state_n = W_RUN;
                        dead_n  = '0;
                    end else if (dead_cnt == DEAD_LAST) begin
                        state_n = W_RUN;
                        fwd_n   = ~fwd;
                        dead_n  = '0;
                    end else begin
                        dead_n = dead_cnt + 1'b1;
                    end
                end
                default: state_n = W_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= W_RUN;
            mag      <= 8'd0;
            fwd      <= 1'b1;
            dead_cnt <= '0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_n;
            mag      <= mag_n;
            fwd      <= fwd_n;
            dead_cnt <= dead_n;
            pwm      <= (pwm_cnt < mag);
        end
    end
endmodule

module motor_drive_ctrl #(
    parameter int unsigned PWM_DIV     = 8,
    parameter int unsigned RAMP_DIV    = 50000,
    parameter int unsigned RAMP_STEP   = 4,
    parameter int unsigned DEADTIME    = 50000,
    parameter logic [7:0]  CRUISE_DUTY = 8'd180,
    parameter logic [7:0]  TURN_DUTY   = 8'd140
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] direction,
    input  logic       estop,
    output logic       left_pwm,
    output logic       left_dir,
    output logic       right_pwm,
    output logic       right_dir,
    output logic       at_speed
);
    localparam int unsigned PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

    logic [3:0]        direction_q;
    logic [PRE_W-1:0]  pwm_pre;
    logic [7:0]        pwm_cnt;
    logic [RAMP_W-1:0] ramp_cnt;
    logic              ramp_tick;
    logic [7:0]        l_tgt_mag, r_tgt_mag;
    logic              l_tgt_fwd, r_tgt_fwd;
    logic              l_ok, r_ok;

    assign ramp_tick = (ramp_cnt == RAMP_LAST);

    always_comb begin
        l_tgt_mag = 8'd0;
        r_tgt_mag = 8'd0;
        l_tgt_fwd = 1'b1;
        r_tgt_fwd = 1'b1;
        case (direction_q)
            4'd1, 4'd3: begin
                l_tgt_mag = CRUISE_DUTY;
                r_tgt_mag = CRUISE_DUTY;
            end
            4'd5, 4'd7: begin
                l_tgt_mag = CRUISE_DUTY;
                r_tgt_mag = CRUISE_DUTY;
                l_tgt_fwd = 1'b0;
                r_tgt_fwd = 1'b0;
            end
            4'd2: begin
                l_tgt_mag = TURN_DUTY;
                r_tgt_mag = TURN_DUTY;
                l_tgt_fwd = 1'b0;
            end
            4'd6: begin
                r_tgt_mag = TURN_DUTY;
                r_tgt_fwd = 1'b0;
            end
            4'd8: begin
                l_tgt_mag = TURN_DUTY;
                r_tgt_mag = TURN_DUTY;
                r_tgt_fwd = 1'b0;
            end
            default: ;
        endcase
    end

    // The PWM counter keeps running through estop; only the ramp timebase restarts.
    always_ff @(posedge clk) begin
        if (reset) begin
            direction_q <= 4'd0;
            pwm_pre     <= '0;
            pwm_cnt     <= 8'd0;
            ramp_cnt    <= '0;
            at_speed    <= 1'b0;
        end else begin
            direction_q <= direction;
            at_speed    <= l_ok && r_ok;
            if (pwm_pre == PRE_LAST) begin
                pwm_pre <= '0;
                pwm_cnt <= pwm_cnt + 8'd1;
            end else begin
                pwm_pre <= pwm_pre + 1'b1;
            end
            if (estop || ramp_tick)
                ramp_cnt <= '0;
            else
                ramp_cnt <= ramp_cnt + 1'b1;
        end
    end

    motor_drive_wheel #(.RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)) u_left (
        .clk       (clk),
        .reset     (reset),
        .estop     (estop),
        .ramp_tick (ramp_tick),
        .pwm_cnt   (pwm_cnt),
        .tgt_mag   (l_tgt_mag),
        .tgt_fwd   (l_tgt_fwd),
        .pwm       (left_pwm),
        .fwd       (left_dir),
        .on_target (l_ok)
    );

    motor_drive_wheel #(.RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)) u_right (
        .clk       (clk),
        .reset     (reset),
        .estop     (estop),
        .ramp_tick (ramp_tick),
        .pwm_cnt   (pwm_cnt),
        .tgt_mag   (r_tgt_mag),
        .tgt_fwd   (r_tgt_fwd),
        .pwm       (right_pwm),
        .fwd       (right_dir),
        .on_target (r_ok)
    );
endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Self-checking bench: two drive controllers (ramp step 4 and 7) run the same
// stimulus and are compared every cycle against a signed-velocity model.

module tb_motor_drive_ctrl;
    localparam int PWM_DIV  = 1;
    localparam int RAMP_DIV = 4;
    localparam int DEADTIME = 8;
    localparam int CRUISE   = 40;
    localparam int TURN     = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] direction;
    logic       estop;
    logic [1:0] lpwm, ldir, rpwm, rdir, aspd;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    motor_drive_ctrl #(
        .PWM_DIV(PWM_DIV), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(4), .DEADTIME(DEADTIME),
        .CRUISE_DUTY(8'd40), .TURN_DUTY(8'd20)
    ) u_dut_s4 (
        .clk(clk), .reset(reset), .direction(direction), .estop(estop),
        .left_pwm(lpwm[0]), .left_dir(ldir[0]), .right_pwm(rpwm[0]),
        .right_dir(rdir[0]), .at_speed(aspd[0])
    );

    motor_drive_ctrl #(
        .PWM_DIV(PWM_DIV), .RAMP_DIV(RAMP_DIV), .RAMP_STEP(7), .DEADTIME(DEADTIME),
        .CRUISE_DUTY(8'd40), .TURN_DUTY(8'd20)
    ) u_dut_s7 (
        .clk(clk), .reset(reset), .direction(direction), .estop(estop),
        .left_pwm(lpwm[1]), .left_dir(ldir[1]), .right_pwm(rpwm[1]),
        .right_dir(rdir[1]), .at_speed(aspd[1])
    );

    // Model state: magnitude, forward flag, dead-time flag and elapsed clocks per wheel.
    int         steps[2] = '{4, 7};
    int         m_mag[2][2];
    bit         m_fwd[2][2];
    bit         m_dead[2][2];
    int         m_del[2][2];
    bit         m_pwm[2][2];
    bit         m_as[2];
    int         m_ph, m_pre, m_pc;
    logic [3:0] m_dq;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int target(input logic [3:0] code, input int w);
        case (code)
            4'd1, 4'd3: return CRUISE;
            4'd5, 4'd7: return -CRUISE;
            4'd2:       return (w == 0) ? -TURN : TURN;
            4'd6:       return (w == 0) ? 0 : -TURN;
            4'd8:       return (w == 0) ? TURN : -TURN;
            default:    return 0;
        endcase
    endfunction

    task automatic model_step(input bit rst, input logic [3:0] d, input bit es);
        bit tick;
        int t, tm;
        bit agree;
        bit ok[2];
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                for (int w = 0; w < 2; w++) begin
                    m_mag[i][w] = 0; m_fwd[i][w] = 1; m_dead[i][w] = 0;
                    m_del[i][w] = 0; m_pwm[i][w] = 0;
                end
                m_as[i] = 0;
            end
            m_ph = 0; m_pre = 0; m_pc = 0; m_dq = 4'd0;
            return;
        end
        tick = (m_ph == RAMP_DIV - 1);
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 2; w++) begin
                t     = target(m_dq, w);
                tm    = (t < 0) ? -t : t;
                agree = (t == 0) || ((t > 0) == m_fwd[i][w]);
                m_pwm[i][w] = (m_pc < m_mag[i][w]);
                ok[w] = !m_dead[i][w] && (m_mag[i][w] == tm) && agree;
                if (es) begin
                    m_mag[i][w]  = 0;
                    m_dead[i][w] = 0;
                    m_del[i][w]  = 0;
                end else if (!m_dead[i][w]) begin
                    if (tick) begin
                        if (agree) begin
                            if (m_mag[i][w] < tm)
                                m_mag[i][w] = (m_mag[i][w] + steps[i] > tm) ? tm : m_mag[i][w] + steps[i];
                            else
                                m_mag[i][w] = (m_mag[i][w] - steps[i] < tm) ? tm : m_mag[i][w] - steps[i];
                        end else if (m_mag[i][w] > 0) begin
                            m_mag[i][w] = (m_mag[i][w] > steps[i]) ? m_mag[i][w] - steps[i] : 0;
                        end else begin
                            m_dead[i][w] = 1;
                            m_del[i][w]  = 0;
                        end
                    end
                end else if (agree) begin
                    m_dead[i][w] = 0;
                end else if (m_del[i][w] == DEADTIME - 1) begin
                    m_fwd[i][w]  = !m_fwd[i][w];
                    m_dead[i][w] = 0;
                end else begin
                    m_del[i][w]++;
                end
            end
            m_as[i] = ok[0] && ok[1];
        end
        m_ph = (es || tick) ? 0 : m_ph + 1;
        if (m_pre == PWM_DIV - 1) begin
            m_pre = 0;
            m_pc  = (m_pc + 1) % 256;
        end else begin
            m_pre++;
        end
        m_dq = d;
    endtask

    task automatic cycle(input logic [3:0] d, input bit es, input bit rst);
        @(negedge clk);
        direction = d;
        estop     = es;
        reset     = rst;
        @(posedge clk);
        model_step(rst, d, es);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("s%0d.left_pwm", steps[i]),  lpwm[i], m_pwm[i][0]);
            check($sformatf("s%0d.left_dir", steps[i]),  ldir[i], m_fwd[i][0]);
            check($sformatf("s%0d.right_pwm", steps[i]), rpwm[i], m_pwm[i][1]);
            check($sformatf("s%0d.right_dir", steps[i]), rdir[i], m_fwd[i][1]);
            check($sformatf("s%0d.at_speed", steps[i]),  aspd[i], m_as[i]);
        end
    endtask

    task automatic settle(input logic [3:0] d, input string tag);
        int budget = 300;
        cycle(d, 0, 0);
        cycle(d, 0, 0);
        while (!(m_as[0] && m_as[1]) && budget > 0) begin
            cycle(d, 0, 0);
            budget--;
        end
        check({tag, ".at_speed"}, aspd[0], 1);
        check({tag, ".at_speed_s7"}, aspd[1], 1);
    endtask

    initial begin
        int budget, low_run, high_cnt[2];
        bit seen_as, flipped;
        int hold, es_hold;
        logic [3:0] rnd_d;

        reset = 1'b1; direction = 4'd0; estop = 1'b0;
        repeat (3) cycle(4'd0, 0, 1);
        check("rst.left_pwm", lpwm[0], 0);
        check("rst.left_dir", ldir[0], 1);
        check("rst.right_dir", rdir[0], 1);
        check("rst.at_speed", aspd[0], 0);

        // Forward cruise, then duty over one full PWM period.
        settle(4'd1, "fwd");
        high_cnt = '{0, 0};
        repeat (256) begin
            cycle(4'd1, 0, 0);
            for (int i = 0; i < 2; i++) high_cnt[i] += int'(lpwm[i]);
        end
        check("fwd.duty_s4", high_cnt[0], CRUISE);
        check("fwd.duty_s7", high_cnt[1], CRUISE);

        // Reverse through dead-time.
        cycle(4'd5, 0, 0);
        cycle(4'd5, 0, 0);
        budget = 200; low_run = 0; seen_as = 0;
        while (ldir[0] == 1'b1 && budget > 0) begin
            cycle(4'd5, 0, 0);
            low_run = lpwm[0] ? 0 : low_run + 1;
            seen_as |= aspd[0];
            budget--;
        end
        check("rev.left_flip", ldir[0], 0);
        check("rev.dead_low", int'(low_run >= DEADTIME), 1);
        check("rev.as_low", seen_as, 0);
        settle(4'd5, "rev");

        // Left pivot from idle, then stop: dirs hold.
        repeat (2) cycle(4'd0, 0, 1);
        budget = 200;
        while (ldir[0] == 1'b1 && budget > 0) begin
            cycle(4'd2, 0, 0);
            budget--;
        end
        check("pivot.left_dir", ldir[0], 0);
        check("pivot.right_dir", rdir[0], 1);
        settle(4'd2, "pivot");
        repeat (60) cycle(4'd4, 0, 0);
        check("stop.left_dir", ldir[0], 0);
        check("stop.right_dir", rdir[0], 1);
        check("stop.at_speed", aspd[0], 1);

        // Emergency stop at cruise, then release without dead-time.
        settle(4'd1, "pre_estop");
        cycle(4'd1, 1, 0);
        cycle(4'd1, 1, 0);
        check("estop.left_pwm", lpwm[0], 0);
        check("estop.right_pwm", rpwm[0], 0);
        cycle(4'd1, 1, 0);
        budget = 200; flipped = 0;
        while (!(m_as[0] && m_as[1]) && budget > 0) begin
            cycle(4'd1, 0, 0);
            flipped |= !ldir[0] || !rdir[0];
            budget--;
        end
        check("estop.no_dead", flipped, 0);
        check("estop.recover", aspd[0], 1);

        // Target reverts to forward while in dead-time.
        budget = 200;
        while (!m_dead[0][0] && budget > 0) begin
            cycle(4'd5, 0, 0);
            budget--;
        end
        check("abort.reach_dead", int'(budget > 0), 1);
        repeat (2) cycle(4'd5, 0, 0);
        repeat (20) cycle(4'd1, 0, 0);
        check("abort.left_dir", ldir[0], 1);
        settle(4'd1, "abort");

        // Reset mid-ramp.
        repeat (2) cycle(4'd0, 0, 1);
        repeat (15) cycle(4'd5, 0, 0);
        cycle(4'd5, 0, 1);
        check("midrst.left_pwm", lpwm[0], 0);
        check("midrst.left_dir", ldir[0], 1);
        check("midrst.right_pwm", rpwm[1], 0);
        check("midrst.right_dir", rdir[1], 1);
        check("midrst.at_speed", aspd[0], 0);

        // Randomised direction codes, estop pulses and occasional reset.
        hold = 0; es_hold = 0; rnd_d = 4'd0;
        for (int k = 0; k < 3000; k++) begin
            if (hold == 0) begin
                rnd_d = 4'($urandom_range(15, 0));
                hold  = $urandom_range(120, 1);
            end
            hold--;
            if (es_hold == 0 && $urandom_range(59, 0) == 0) es_hold = $urandom_range(4, 1);
            cycle(rnd_d, es_hold > 0, $urandom_range(499, 0) == 0);
            if (es_hold > 0) es_hold--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
